// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern-matcher arbiter: FSM encoding and
// the default 11011 pattern.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam int                     DEF_PAT_LEN = 5;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b11011;

endpackage

// File: rtl/pattern_shift_match.sv
// Serial overlapping pattern matcher: keeps the previous PAT_LEN-1 bits and
// flags a match combinationally when the current bit completes the pattern.
module pattern_shift_match
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic input_pulse,
  input  logic clear,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic match
);

  localparam int HW = PAT_LEN - 1;
  localparam int FW = $clog2(PAT_LEN);

  logic [HW-1:0]      hist_q;
  logic [FW-1:0]      fill_q;
  logic [PAT_LEN-1:0] window;

  // Oldest bit lands in the MSB, so the window lines up with PATTERN directly.
  assign window = {hist_q, bit_in};
  assign match  = en && (fill_q == FW'(HW)) && (window == PATTERN);

  always_ff @(posedge input_pulse or posedge clear) begin
    if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (en) begin
      hist_q <= window[HW-1:0];
      if (fill_q != FW'(HW)) fill_q <= fill_q + FW'(1);
    end
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin front end that feeds one requester word at a time, MSB first,
// through the shared serial matcher and reports the match count per word.
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int                 NREQ    = 4,
  parameter int                 WORD_W  = 16,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = 5
) (
  input  logic                     input_pulse,
  input  logic                     clear,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   word_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     bit_out,
  output logic                     match_flag,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [1:0]               dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(WORD_W + 1);

  // Handshake: a requester raises req[i] with word_in slice i stable and keeps
  // both until it sees its one-cycle gnt[i]; gnt means the word has been taken.
  state_e              state_q;
  logic [IDW-1:0]      ptr_q, id_q, done_id_q;
  logic [WORD_W-1:0]   word_q;
  logic [BW-1:0]       bitcnt_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d, match_cnt_q;
  logic [NREQ-1:0]     gnt_q;
  logic                bit_out_q, done_q;
  logic                pick_valid;
  logic [IDW-1:0]      pick_id, ptr_d;
  logic                match;

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    // Scan downward so the requester closest to ptr is the last, winning write.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % NREQ]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
    ptr_d = IDW'((int'(pick_id) + 1) % NREQ);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  pattern_shift_match #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_match (
    .input_pulse (input_pulse),
    .clear       (clear),
    .clr         (state_q == ST_LOAD),
    .en          (state_q == ST_SHIFT),
    .bit_in      (bit_out_q),
    .match       (match)
  );

  always_ff @(posedge input_pulse or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      word_q      <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      bit_out_q   <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_LOAD;
            gnt_q   <= NREQ'(1) << pick_id;
            word_q  <= word_in[int'(pick_id)*WORD_W +: WORD_W];
            id_q    <= pick_id;
            ptr_q   <= ptr_d;
          end
        end
        ST_LOAD: begin
          state_q   <= ST_SHIFT;
          bit_out_q <= word_q[WORD_W-1];
          word_q    <= word_q << 1;
          bitcnt_q  <= BW'(1);
          cnt_q     <= '0;
        end
        ST_SHIFT: begin
          cnt_q <= cnt_d;
          if (bitcnt_q == BW'(WORD_W)) begin
            state_q     <= ST_REPORT;
            bit_out_q   <= 1'b0;
            done_q      <= 1'b1;
            done_id_q   <= id_q;
            match_cnt_q <= cnt_d;
          end else begin
            bit_out_q <= word_q[WORD_W-1];
            word_q    <= word_q << 1;
            bitcnt_q  <= bitcnt_q + BW'(1);
          end
        end
        ST_REPORT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign bit_out    = bit_out_q;
  assign match_flag = match;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign match_cnt  = match_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: directed words plus randomized requests, checked
// against a sliding-window pattern model and a round-robin pick model.
module tb_seq_det_arbiter;

  localparam int          NREQ    = 4;
  localparam int          WORD_W  = 16;
  localparam int          PAT_LEN = 5;
  localparam int          CNT_W   = 5;
  localparam logic [4:0]  PATTERN = 5'b11011;

  logic                    input_pulse;
  logic                    clear;
  logic [NREQ-1:0]         req;
  logic [NREQ*WORD_W-1:0]  word_in;
  logic [NREQ-1:0]         gnt;
  logic                    busy, bit_out, match_flag, done;
  logic [1:0]              done_id;
  logic [CNT_W-1:0]        match_cnt;
  logic [1:0]              dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int rr_ptr   = 0;
  logic [WORD_W-1:0] exp_q[$];

  seq_det_arbiter #(
    .NREQ(NREQ), .WORD_W(WORD_W), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(CNT_W)
  ) dut (
    .input_pulse (input_pulse),
    .clear       (clear),
    .req         (req),
    .word_in     (word_in),
    .gnt         (gnt),
    .busy        (busy),
    .bit_out     (bit_out),
    .match_flag  (match_flag),
    .done        (done),
    .done_id     (done_id),
    .match_cnt   (match_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    input_pulse = 1'b0;
    forever #5 input_pulse = ~input_pulse;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit model_match(input logic [WORD_W-1:0] w, input int k);
    logic [WORD_W-1:0] win;
    if (k < PAT_LEN) return 1'b0;
    win = (w >> (WORD_W - k)) & WORD_W'((1 << PAT_LEN) - 1);
    return win == WORD_W'(PATTERN);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_word(input int id, input logic [WORD_W-1:0] w);
    word_in[id*WORD_W +: WORD_W] = w;
  endtask

  // One full transaction: grant, WORD_W shifted bits, done, then back to idle.
  task automatic run_txn(input bit drop);
    int w, waited, exp_cnt;
    logic [NREQ-1:0]   exp_gnt;
    logic [WORD_W-1:0] wd;
    bit exp_m;
    w = model_pick(req, rr_ptr);
    exp_gnt = (w >= 0) ? NREQ'(1 << w) : '0;
    waited = 0;
    do begin
      @(negedge input_pulse);
      waited++;
    end while (gnt == '0 && waited < 40);
    n_checks++;
    if (gnt !== exp_gnt || w < 0) begin
      n_errors++;
      $display("FAIL gnt: got %b want %b (waited %0d)", gnt, exp_gnt, waited);
      return;
    end
    rr_ptr = (w + 1) % NREQ;
    wd = word_in[w*WORD_W +: WORD_W];
    exp_q.push_back(wd);
    if (drop) req[w] = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_load: got %b want 1", busy);
    end
    exp_cnt = 0;
    for (int k = 1; k <= WORD_W; k++) begin
      @(negedge input_pulse);
      exp_m = model_match(exp_q[0], k);
      n_checks++;
      if (bit_out !== wd[WORD_W-k]) begin
        n_errors++;
        $display("FAIL bit_out k=%0d: got %b want %b", k, bit_out, wd[WORD_W-k]);
      end
      n_checks++;
      if (match_flag !== exp_m) begin
        n_errors++;
        $display("FAIL match_flag k=%0d word=%h: got %b want %b", k, wd, match_flag, exp_m);
      end
      n_checks++;
      if (done !== 1'b0) begin
        n_errors++;
        $display("FAIL done_early k=%0d: got %b want 0", k, done);
      end
      if (exp_m && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    end
    void'(exp_q.pop_front());
    @(negedge input_pulse);
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL done: got %b want 1", done);
    end
    n_checks++;
    if (done_id !== 2'(w)) begin
      n_errors++;
      $display("FAIL done_id: got %0d want %0d", done_id, w);
    end
    n_checks++;
    if (match_cnt !== CNT_W'(exp_cnt)) begin
      n_errors++;
      $display("FAIL match_cnt word=%h: got %0d want %0d", wd, match_cnt, exp_cnt);
    end
    n_checks++;
    if (bit_out !== 1'b0 || match_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL report_quiet: got bit_out=%b match_flag=%b want 0 0", bit_out, match_flag);
    end
    @(negedge input_pulse);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after: got done=%b busy=%b want 0 0", done, busy);
    end
    n_checks++;
    if (done_id !== 2'(w) || match_cnt !== CNT_W'(exp_cnt)) begin
      n_errors++;
      $display("FAIL held: got id=%0d cnt=%0d want id=%0d cnt=%0d", done_id, match_cnt, w, exp_cnt);
    end
  endtask

  task automatic pulse_clear();
    @(negedge input_pulse);
    clear = 1'b1;
    @(negedge input_pulse);
    clear = 1'b0;
    rr_ptr = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear = 1'b1;
    req = '0;
    word_in = '0;
    repeat (2) @(negedge input_pulse);
    n_checks++;
    if ({gnt, busy, bit_out, match_flag, done, done_id, match_cnt, dbg_state} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b bit=%b mf=%b done=%b id=%0d cnt=%0d st=%0d want all 0",
               gnt, busy, bit_out, match_flag, done, done_id, match_cnt, dbg_state);
    end
    clear = 1'b0;
    rr_ptr = 0;
  endtask

  task automatic test_single();
    set_word(1, 16'hDB00);
    req = 4'b0010;
    run_txn(1);
  endtask

  task automatic test_overlap();
    set_word(3, 16'hDB6D);
    req = 4'b1000;
    run_txn(1);
  endtask

  task automatic test_no_match();
    set_word(2, 16'hFFFF);
    req = 4'b0100;
    run_txn(1);
    set_word(2, 16'h0000);
    req = 4'b0100;
    run_txn(1);
  endtask

  task automatic test_cross_word();
    set_word(0, 16'h000D);
    req = 4'b0001;
    run_txn(1);
    set_word(0, 16'hB000);
    req = 4'b0001;
    run_txn(1);
  endtask

  task automatic test_reset_mid_shift();
    int waited;
    set_word(2, 16'hDB6D);
    req = 4'b0100;
    waited = 0;
    do begin
      @(negedge input_pulse);
      waited++;
    end while (gnt == '0 && waited < 40);
    req = '0;
    repeat (7) @(negedge input_pulse);
    #2 clear = 1'b1;
    #1;
    n_checks++;
    if ({gnt, busy, bit_out, match_flag, done, done_id, match_cnt, dbg_state} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_shift: got gnt=%b busy=%b bit=%b mf=%b done=%b id=%0d cnt=%0d st=%0d want all 0",
               gnt, busy, bit_out, match_flag, done, done_id, match_cnt, dbg_state);
    end
    @(negedge input_pulse);
    clear = 1'b0;
    rr_ptr = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge input_pulse);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL no_done_after_reset c=%0d: got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    // With ptr back at 0 requester 1 wins; a stale ptr of 3 would pick 3.
    set_word(1, 16'h1B1B);
    set_word(3, 16'hDB6D);
    req = 4'b1010;
    run_txn(1);
    req = '0;
  endtask

  task automatic test_round_robin();
    pulse_clear();
    for (int i = 0; i < NREQ; i++) set_word(i, 16'($urandom));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) run_txn(0);
    req = '0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) set_word(i, 16'hDB6D ^ 16'($urandom_range(0, 7)));
        else set_word(i, 16'($urandom));
      end
      req = 4'($urandom_range(1, 15));
      run_txn(1'($urandom_range(0, 1)));
    end
    req = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_no_match();
    test_cross_word();
    test_reset_mid_shift();
    test_round_robin();
    test_random();
    repeat (3) @(negedge input_pulse);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
